// File: rtl/memdump_ctrl_pkg.sv
// ============================================================================
// Module      : memdump_ctrl_pkg
// Description : Shared constants, NOP encodings and FSM state type for the
//               post-run memory dumper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package memdump_ctrl_pkg;

    localparam int          DATAMEM_BITS = 10;
    localparam int          WORD_BITS    = 32;
    localparam logic [15:0] C_NOP        = 16'h0001;
    localparam logic [31:0] I_NOP        = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_MON  = 3'd0,
        S_ADDR = 3'd1,
        S_RDWT = 3'd2,
        S_SEND = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Compressed NOP only needs the low halfword; the upper half may hold the next instruction.
    function automatic logic is_nop(input logic [31:0] inst);
        return (inst[15:0] == C_NOP) || (inst == I_NOP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/memdump_ctrl_halt_detector.sv
// ============================================================================
// Module      : memdump_ctrl_halt_detector
// Description : Flags program completion when the IF-stage instruction stops
//               changing (NOP repeats or any long stall). Sticky until reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memdump_ctrl_halt_detector
    import memdump_ctrl_pkg::*;
#(
    parameter int NOP_LIMIT   = 16,
    parameter int STALL_LIMIT = 49
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] i_inst,
    output logic        o_halted
);

    localparam int NOP_W   = $clog2(NOP_LIMIT + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [31:0]        r_last_inst;
    logic [NOP_W-1:0]   r_nop_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_halted;

    logic               w_is_nop;
    logic [NOP_W-1:0]   w_nop_next;
    logic [STALL_W-1:0] w_stall_next;

    assign w_is_nop     = is_nop(i_inst);
    assign w_nop_next   = r_nop_cnt + 1'b1;
    assign w_stall_next = r_stall_cnt + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last_inst <= '0;
            r_nop_cnt   <= '0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
        end else if (!r_halted) begin
            if (i_inst != r_last_inst) begin
                r_last_inst <= i_inst;
                r_nop_cnt   <= '0;
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= w_stall_next;
                if (w_is_nop) begin
                    r_nop_cnt <= w_nop_next;
                end
                if ((w_is_nop && (w_nop_next == NOP_W'(NOP_LIMIT))) ||
                    (w_stall_next == STALL_W'(STALL_LIMIT))) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign o_halted = r_halted;

endmodule

`default_nettype wire

// File: rtl/memdump_ctrl.sv
// ============================================================================
// Module      : memdump_ctrl
// Description : Walks the data-memory console port after program completion
//               and streams every word MSB-first to the UART, then an XOR csum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memdump_ctrl
    import memdump_ctrl_pkg::*;
#(
    parameter int ADDR_BITS   = DATAMEM_BITS,
    parameter int WORD_WIDTH  = WORD_BITS,
    parameter int NOP_LIMIT   = 16,
    parameter int STALL_LIMIT = 49,
    parameter int DUMP_LAST   = 143
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [31:0]           if_inst,
    input  logic                  dump_req,
    output logic [ADDR_BITS-1:0]  con_addr,
    output logic [3:0]            con_write,
    input  logic [WORD_WIDTH-1:0] con_out,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  halted,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_t                r_state;
    logic [ADDR_BITS-1:0]  r_addr_cnt;
    logic [ADDR_BITS-1:0]  r_con_addr;
    logic [WORD_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_csum;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_halted_d;

    logic                  w_halted;
    logic                  w_halt_rise;
    logic                  w_accept;
    logic                  w_last_word;
    logic [IDX_W-1:0]      w_idx_dn;
    logic [WORD_WIDTH-1:0] w_shifted;
    logic [7:0]            w_csum_next;
    logic [ADDR_BITS-1:0]  w_addr_inc;

    memdump_ctrl_halt_detector #(
        .NOP_LIMIT   (NOP_LIMIT),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_halt_detector (
        .clk      (clk),
        .nrst     (nrst),
        .i_inst   (if_inst),
        .o_halted (w_halted)
    );

    assign w_halt_rise = w_halted & ~r_halted_d;
    assign w_accept    = r_tx_valid & tx_ready;
    assign w_last_word = (r_addr_cnt == ADDR_BITS'(DUMP_LAST));
    assign w_idx_dn    = r_idx - 1'b1;
    assign w_shifted   = r_word >> {w_idx_dn, 3'b000};
    // r_tx_data always holds the byte currently offered, so it is the one folded in.
    assign w_csum_next = r_csum ^ r_tx_data;
    assign w_addr_inc  = r_addr_cnt + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_MON;
            r_addr_cnt <= '0;
            r_con_addr <= '0;
            r_word     <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_halted_d <= 1'b0;
        end else begin
            r_halted_d <= w_halted;
            case (r_state)
                S_MON: begin
                    if (w_halt_rise || dump_req) begin
                        r_state    <= S_ADDR;
                        r_con_addr <= r_addr_cnt;
                        r_busy     <= 1'b1;
                    end
                end
                S_ADDR: begin
                    r_con_addr <= r_addr_cnt;
                    r_state    <= S_RDWT;
                end
                S_RDWT: begin
                    r_word     <= con_out;
                    r_tx_data  <= con_out[WORD_WIDTH-1 -: 8];
                    r_idx      <= IDX_W'(BYTES - 1);
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_csum <= w_csum_next;
                        if (r_idx == '0) begin
                            if (w_last_word) begin
                                r_tx_data <= w_csum_next;
                                r_state   <= S_CSUM;
                            end else begin
                                r_tx_valid <= 1'b0;
                                r_addr_cnt <= w_addr_inc;
                                r_con_addr <= w_addr_inc;
                                r_state    <= S_ADDR;
                            end
                        end else begin
                            r_idx     <= w_idx_dn;
                            r_tx_data <= w_shifted[7:0];
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_MON;
                end
            endcase
        end
    end

    assign con_addr  = r_con_addr;
    assign con_write = 4'b0000;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign halted    = w_halted;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire
